// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit definitions.
// Reset values, opcode width and fetch state encodings.
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned OP_W      = 7;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus.
// The fetch unit is master, the memory is slave.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection, PC+4 adder and target alignment check.
// Purely combinational; the caller decides when to load.
module pc_next (
    input  logic [31:0] pc,
    input  logic [31:0] pc_target,
    input  logic        sel_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic        misalign
);

    // PC+4 wraps naturally at 2^32
    assign pc_plus4 = pc + 32'd4;

    // Target is forced to a word boundary; low bits flag an error
    always_comb begin
        npc      = pc_plus4;
        misalign = 1'b0;
        if (sel_target) begin
            npc      = {pc_target[31:2], 2'b00};
            misalign = (pc_target[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit.
// Requests one word, holds it until consumed, handles flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = instr_fetch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             PCSrc,
    input  logic [31:0]                      PCTarget,
    input  logic                             flush,
    instr_fetch_if.master                    imem,
    output logic [31:0]                      PC,
    output logic [31:0]                      PCPlus4,
    output logic [31:0]                      Instr,
    output logic [instr_fetch_pkg::OP_W-1:0] op,
    output logic                             InstrValid,
    output logic                             misalign_err
);

    import instr_fetch_pkg::*;

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        misalign;
    logic        consume;

    assign consume = (state_q == S_HOLD) && !stall && !flush;

    pc_next u_pc_next (
        .pc         (pc_q),
        .pc_target  (PCTarget),
        .sel_target (flush | PCSrc),
        .pc_plus4   (pc_plus4),
        .npc        (npc),
        .misalign   (misalign)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a grant or flush never leaves a response unaccounted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (flush) begin
                    state_d = imem.imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem.imem_rvalid) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || !stall) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Bus outputs decoded from state; no request while in reset
    always_comb begin
        imem.imem_req  = reset && (state_q == S_REQ);
        imem.imem_addr = pc_q;
    end

    // Datapath next values: flush wins over response and consume
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        if (flush) begin
            pc_d    = npc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            mis_d   = misalign;
        end else if (state_q == S_WAIT && imem.imem_rvalid) begin
            instr_d = imem.imem_rdata;
            valid_d = 1'b1;
        end else if (consume) begin
            pc_d    = npc;
            valid_d = 1'b0;
            mis_d   = misalign;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign Instr        = instr_q;
    assign op           = instr_q[OP_W-1:0];
    assign InstrValid   = valid_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch.
// Transaction-level reference model plus directed scenarios.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        flush;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic        InstrValid;
    logic        misalign_err;

    instr_fetch_if imem_if ();

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget),
        .flush        (flush),
        .imem         (imem_if),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .Instr        (Instr),
        .op           (op),
        .InstrValid   (InstrValid),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: expected architectural view
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;
    logic        m_out;
    logic        m_disc;

    // memory responder state
    logic        mp;
    int          md;
    logic [31:0] ma;
    int          cur_lat;
    int          mem_lat;
    int          gnt_pct;
    logic        spur;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:7] ^ 25'h1555555, a[8:2] ^ 7'h2B};
    endfunction

    function automatic logic m_req();
        return !m_out && !m_valid;
    endfunction

    task automatic compare();
        chk("pc", PC, m_pc);
        chk("pc4", PCPlus4, m_pc + 32'd4);
        chk("instr", Instr, m_instr);
        chk("op", {25'b0, op}, {25'b0, m_instr[6:0]});
        chk("valid", {31'b0, InstrValid}, {31'b0, m_valid});
        chk("mis", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("req", {31'b0, imem_if.imem_req}, {31'b0, m_req()});
        if (m_req()) chk("addr", imem_if.imem_addr, m_pc);
    endtask

    task automatic drive();
        imem_if.imem_gnt = m_req() && !mp &&
                           ($urandom_range(99) < gnt_pct);
        if (imem_if.imem_gnt)
            cur_lat = (mem_lat < 0) ? int'($urandom_range(2)) : mem_lat;
        if (mp && md == 0) begin
            imem_if.imem_rvalid = 1'b1;
            imem_if.imem_rdata  = memword(ma);
        end else if (!mp && spur && $urandom_range(9) == 0) begin
            imem_if.imem_rvalid = 1'b1;
            imem_if.imem_rdata  = $urandom;
        end else begin
            imem_if.imem_rvalid = 1'b0;
            imem_if.imem_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        logic        req;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [31:0] a;
        req = m_req();
        g   = imem_if.imem_gnt;
        rv  = imem_if.imem_rvalid;
        rd  = imem_if.imem_rdata;
        a   = imem_if.imem_addr;
        @(posedge clk);
        if (flush) begin
            m_mis   = (PCTarget[1:0] != 2'b00);
            m_pc    = {PCTarget[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP;
            if (req && g) begin
                m_out  = 1'b1;
                m_disc = 1'b1;
            end else if (m_out && rv) begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            m_mis = 1'b0;
            if (req && g) begin
                m_out  = 1'b1;
                m_disc = 1'b0;
            end else if (m_out && rv) begin
                if (!m_disc) begin
                    m_instr = rd;
                    m_valid = 1'b1;
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (m_valid && !stall) begin
                if (PCSrc) begin
                    m_mis = (PCTarget[1:0] != 2'b00);
                    m_pc  = {PCTarget[31:2], 2'b00};
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                m_valid = 1'b0;
            end
        end
        if (rv && mp && md == 0) begin
            mp = 1'b0;
        end else if (g) begin
            mp = 1'b1;
            md = cur_lat;
            ma = a;
        end else if (mp && md > 0) begin
            md--;
        end
        #1;
        compare();
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
        imem_if.imem_gnt    = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        imem_if.imem_rdata  = 32'h0;
        m_pc    = RST_PC;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_out   = 1'b0;
        m_disc  = 1'b0;
        mp      = 1'b0;
        md      = 0;
        #1;
        chk("rst_pc", PC, RST_PC);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_op", {25'b0, op}, 32'h0);
        chk("rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'h0);
        chk("rst_req", {31'b0, imem_if.imem_req}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_if.imem_req}, 32'h1);
    endtask

    task automatic fetch_one();
        flush = 1'b0;
        stall = 1'b1;
        PCSrc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) break;
            step();
        end
        chk("fetch_valid", {31'b0, InstrValid}, 32'h1);
    endtask

    task automatic rand_run(input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            flush = ($urandom_range(15) == 0);
            stall = $urandom_range(1);
            PCSrc = $urandom_range(1);
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(31) == 0) t = 32'hFFFF_FFFC;
            PCTarget = t;
            step();
        end
    endtask

    initial begin
        gnt_pct = 100;
        mem_lat = 0;
        spur    = 1'b0;
        cur_lat = 0;
        ma      = 32'h0;
        do_reset();

        // first fetch: gnt in first REQ cycle, rvalid one later
        step();
        step();
        chk("r042_valid", {31'b0, InstrValid}, 32'h1);
        chk("r042_pc", PC, 32'h0);
        chk("r042_op", {25'b0, op}, 32'h13);

        // hold under stall, then sequential consume
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r043_req", {31'b0, imem_if.imem_req}, 32'h0);
            chk("r043_instr", Instr, 32'h0050_0093);
        end
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        chk("r043_addr", imem_if.imem_addr, 32'h4);

        // taken redirect on consume
        fetch_one();
        PCSrc    = 1'b1;
        PCTarget = 32'h100;
        stall    = 1'b0;
        step();
        chk("r044_addr", imem_if.imem_addr, 32'h100);
        fetch_one();
        chk("r044_pc4", PCPlus4, 32'h104);

        // flush in WAIT, stale response arrives later
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        stall   = 1'b1;
        mem_lat = 2;
        step();
        flush    = 1'b1;
        PCTarget = 32'h200;
        step();
        flush   = 1'b0;
        mem_lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_req()) break;
            step();
            chk("r045_nostale", Instr, NOP);
        end
        chk("r045_addr", imem_if.imem_addr, 32'h200);

        // misaligned taken target
        fetch_one();
        PCSrc    = 1'b1;
        PCTarget = 32'h302;
        stall    = 1'b0;
        step();
        chk("r046_mis", {31'b0, misalign_err}, 32'h1);
        chk("r046_addr", imem_if.imem_addr, 32'h300);
        PCSrc = 1'b0;
        stall = 1'b1;
        step();
        chk("r046_pulse", {31'b0, misalign_err}, 32'h0);

        // PC+4 wrap at top of address space
        flush    = 1'b1;
        PCTarget = 32'hFFFF_FFFC;
        step();
        fetch_one();
        chk("r047_pc", PC, 32'hFFFF_FFFC);
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        chk("r047_addr", imem_if.imem_addr, 32'h0);
        chk("r047_mis", {31'b0, misalign_err}, 32'h0);

        // randomized traffic with a mid-run reset
        gnt_pct = 60;
        mem_lat = -1;
        spur    = 1'b1;
        rand_run(1500);
        do_reset();
        rand_run(1500);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, the instruction value presented while no instruction is valid after a flush.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  downstream not ready; hold the presented instruction.
REQ-006 PCSrc  in  1  redirect on consume: 1 selects PCTarget, 0 selects PC+4.
REQ-007 PCTarget  in  32  branch, jal or jalr target.
REQ-008 flush  in  1  immediate redirect to PCTarget in any state.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  32  request address, word aligned.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  response data valid.
REQ-013 imem_rdata  in  32  response instruction word.
REQ-014 PC  out  32  address of Instr.
REQ-015 PCPlus4  out  32  PC+4, modulo 2^32.
REQ-016 Instr  out  32  registered instruction word.
REQ-017 op  out  7  Instr[6:0], feeds the main decoder.
REQ-018 InstrValid  out  1  Instr and PC are valid.
REQ-019 misalign_err  out  1  one-cycle pulse on a misaligned target.

Function
REQ-020 States: REQ, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-021 REQ: imem_req=1, imem_addr=PC; on imem_gnt go to WAIT; otherwise stay in REQ.
REQ-022 WAIT: imem_req=0; on imem_rvalid, Instr<=imem_rdata and InstrValid<=1 at the same edge; go to HOLD.
REQ-023 HOLD: with stall=1, PC, Instr and InstrValid hold.
REQ-024 HOLD with stall=0 consumes the instruction: PC<=(PCSrc ? PCTarget : PC+4) and InstrValid<=0; go to REQ.
REQ-025 PCSrc and PCTarget are sampled only on a HOLD consume or on flush; they are ignored otherwise.
REQ-026 Minimum latency is gnt in the REQ cycle plus rvalid one cycle later: InstrValid rises 2 cycles after REQ is entered; throughput is one instruction per 3 cycles.
REQ-027 flush=1 in REQ or HOLD: PC<=PCTarget, InstrValid<=0, Instr<=NOP_INSTR; go to REQ.
REQ-028 flush=1 in REQ takes priority over an imem_gnt in the same cycle; that grant is treated as outstanding, so the block goes to DRAIN instead of REQ.
REQ-029 flush=1 in WAIT without imem_rvalid: PC<=PCTarget, InstrValid<=0, Instr<=NOP_INSTR; go to DRAIN.
REQ-030 flush=1 in WAIT with imem_rvalid: the response is discarded; PC<=PCTarget, InstrValid<=0, Instr<=NOP_INSTR; go to REQ.
REQ-031 DRAIN: imem_req=0; the next imem_rvalid is discarded, then go to REQ; a flush in DRAIN updates PC and stays in DRAIN.
REQ-032 flush has priority over stall and over PCSrc.
REQ-033 Any target load with PCTarget[1:0]!=0: PC<={PCTarget[31:2],2'b00} and misalign_err=1 for exactly one cycle.
REQ-034 imem_rvalid outside WAIT and DRAIN is ignored.
REQ-035 PC+4 at 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.
REQ-036 op is combinational from Instr; all other outputs are registered or decoded from state.

Reset
REQ-037 Reset asserted (reset=0) asynchronously sets: PC=RESET_PC, Instr=32'h0000_0000 (op=7'b0000000, the decoder's reset opcode), InstrValid=0, misalign_err=0, state=REQ.
REQ-038 imem_req is 0 while reset is asserted and 1 in the first cycle after reset deasserts.
REQ-039 Reset mid-transaction abandons any outstanding response; the memory side is reset by the same signal.

Structure
REQ-040 The shared package holds RESET_PC, NOP_INSTR, the fetch state encodings and the opcode width constant.
REQ-041 Next-PC selection, the PC+4 adder and the alignment check form one sub-module, pc_next, which is combinational; the FSM and registers stay in instr_fetch.

Verification
REQ-042 Reset release with gnt the same cycle and rvalid +1 returning 32'h00500093: InstrValid=1 two cycles after the first REQ cycle, PC=0, op=7'b0010011.
REQ-043 HOLD with stall=1 for 5 cycles: PC, Instr and InstrValid stable, imem_req=0; on stall=0 with PCSrc=0, next imem_addr=0x4.
REQ-044 Consume with PCSrc=1 and PCTarget=0x100: next imem_addr=0x100, PCPlus4=0x104 once that instruction is valid.
REQ-045 flush in WAIT with PCTarget=0x200 and stale rvalid 2 cycles later: stale data never appears on Instr; next request address is 0x200.
REQ-046 Consume with PCSrc=1 and PCTarget=0x302: misalign_err pulses one cycle, imem_addr=0x300.
REQ-047 PC=0xFFFF_FFFC consumed with PCSrc=0: next imem_addr=0x0000_0000, no error.
